// File: rtl/pipe_chain_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_chain_ctrl
//
// Valid/allow-in handshake controller for a linear chain of STAGES pipeline
// stages. Each stage latches WIDTH bits of payload. An item leaves stage i when
// that stage's logic reports it is finished and stage i+1 can take it. A flush
// request from stage k cancels every younger stage (0..k-1). The block also
// keeps retire and flush counters and a registered occupancy count.
//
// Ports
//   clk           clock, rising edge
//   resetn        synchronous active-low reset
//   in_valid      item offered to stage 0
//   in_data       payload of the offered item
//   in_ready      stage 0 accepts the offered item this cycle
//   stage_over    bit i: stage i logic has finished its current item
//   nxt_bus       slice i: payload stage i hands to stage i+1
//   flush_req     bit k: cancel stages 0..k-1 (bit 0 has no effect)
//   stage_valid   per-stage valid flags
//   stage_data    per-stage payload, slice i = stage i
//   allow_in      per-stage allow-in
//   retire_valid  last stage retires this cycle
//   retire_data   payload of the retiring item
//   occupancy     number of valid stages (registered)
//   retire_cnt    retired items, wrapping
//   flush_cnt     cycles with an effective flush, saturating
// -----------------------------------------------------------------------------
module pipe_chain_ctrl #(
    parameter int STAGES = 5,
    parameter int WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    input  logic [STAGES-1:0]             stage_over,
    input  logic [(STAGES-1)*WIDTH-1:0]   nxt_bus,
    input  logic [STAGES-1:0]             flush_req,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*WIDTH-1:0]       stage_data,
    output logic [STAGES-1:0]             allow_in,
    output logic                          retire_valid,
    output logic [WIDTH-1:0]              retire_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic [31:0]                   retire_cnt,
    output logic [15:0]                   flush_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [OCC_W-1:0]  r_occ;
    logic [31:0]       r_retire_cnt;
    logic [15:0]       r_flush_cnt;

    logic [STAGES-1:0] w_allow;
    logic [STAGES-1:0] w_kill;
    logic [STAGES-2:0] w_move;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_nxt;
    logic [WIDTH-1:0]  w_din [STAGES];
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              w_any_flush;
    logic              w_accept;
    logic              w_retire;
    logic              w_flush0_unused;

    // A flush from stage 0 would cancel nothing, so that bit is not used.
    assign w_flush0_unused = flush_req[0];

    // kill[i] is set when any older stage (index above i) requests a flush.
    always_comb begin
        logic v_acc;
        v_acc  = 1'b0;
        w_kill = '0;
        for (int i = STAGES-1; i >= 1; i--) begin
            v_acc       = v_acc | flush_req[i];
            w_kill[i-1] = v_acc;
        end
    end

    assign w_any_flush = w_kill[0];

    // Allow-in ripples back from the last stage: a stage can take an item if
    // it is empty or its own item is leaving this cycle.
    always_comb begin
        logic v_ok;
        w_allow = '0;
        v_ok    = ~r_valid[STAGES-1] | stage_over[STAGES-1];
        w_allow[STAGES-1] = v_ok;
        for (int i = STAGES-2; i >= 0; i--) begin
            v_ok       = ~r_valid[i] | (stage_over[i] & v_ok);
            w_allow[i] = v_ok;
        end
    end

    always_comb begin
        w_move = '0;
        for (int i = 0; i < STAGES-1; i++) begin
            w_move[i] = r_valid[i] & stage_over[i] & w_allow[i+1] & ~w_kill[i];
        end
    end

    assign in_ready = w_allow[0] & ~w_any_flush;
    assign w_accept = in_valid & in_ready;
    assign w_retire = r_valid[STAGES-1] & stage_over[STAGES-1];

    assign w_din[0] = in_data;
    for (genvar g = 1; g < STAGES; g++) begin : g_din
        assign w_din[g] = nxt_bus[(g-1)*WIDTH +: WIDTH];
    end

    // Next valid and data-load enables. Flush wins over everything; data is
    // only written when a real item arrives, so stalls and flushes never
    // disturb stored payloads.
    always_comb begin
        w_valid_nxt = r_valid;
        w_load      = '0;
        if (w_kill[0]) begin
            w_valid_nxt[0] = 1'b0;
        end else if (w_allow[0]) begin
            w_valid_nxt[0] = w_accept;
            w_load[0]      = w_accept;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (w_kill[i]) begin
                w_valid_nxt[i] = 1'b0;
            end else if (w_move[i-1]) begin
                w_valid_nxt[i] = 1'b1;
                w_load[i]      = 1'b1;
            end else if (w_allow[i]) begin
                w_valid_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid      <= '0;
            r_occ        <= '0;
            r_retire_cnt <= '0;
            r_flush_cnt  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= w_din[i];
                end
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            if (w_any_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign stage_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign stage_valid  = r_valid;
    assign allow_in     = w_allow;
    assign retire_valid = w_retire;
    assign retire_data  = r_data[STAGES-1];
    assign occupancy    = r_occ;
    assign retire_cnt   = r_retire_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain_ctrl
//
// Bench for pipe_chain_ctrl (STAGES=5, WIDTH=8): directed scenarios followed
// by randomized traffic, all compared against an item-level model of the
// stage chain kept in the bench.
// -----------------------------------------------------------------------------
module tb_pipe_chain_ctrl;

    localparam int S  = 5;
    localparam int W  = 8;
    localparam int OW = $clog2(S+1);

    logic                 clk;
    logic                 resetn;
    logic                 in_valid;
    logic [W-1:0]         in_data;
    logic                 in_ready;
    logic [S-1:0]         stage_over;
    logic [(S-1)*W-1:0]   nxt_bus;
    logic [S-1:0]         flush_req;
    logic [S-1:0]         stage_valid;
    logic [S*W-1:0]       stage_data;
    logic [S-1:0]         allow_in;
    logic                 retire_valid;
    logic [W-1:0]         retire_data;
    logic [OW-1:0]        occupancy;
    logic [31:0]          retire_cnt;
    logic [15:0]          flush_cnt;

    pipe_chain_ctrl #(.STAGES(S), .WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stage_over   (stage_over),
        .nxt_bus      (nxt_bus),
        .flush_req    (flush_req),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .allow_in     (allow_in),
        .retire_valid (retire_valid),
        .retire_data  (retire_data),
        .occupancy    (occupancy),
        .retire_cnt   (retire_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: which stages hold an item and what that item is.
    bit          m_v [S];
    logic [W-1:0] m_d [S];
    logic [31:0] m_rc;
    int          m_fc;
    bit          xform;

    logic        obs_ret;
    logic [W-1:0] obs_rdata;
    logic        obs_rdy;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // What stage i's logic hands onward: passthrough in directed tests, a
    // stage-dependent increment in the random phase.
    function automatic logic [W-1:0] stage_fn(input int i, input logic [W-1:0] d);
        return xform ? (d + W'(i+1)) : d;
    endfunction

    function automatic logic [S-1:0] pack_v();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = m_v[i];
        return v;
    endfunction

    function automatic logic [S*W-1:0] pack_d();
        logic [S*W-1:0] d;
        for (int i = 0; i < S; i++) d[i*W +: W] = m_d[i];
        return d;
    endfunction

    // A stage can take an item if empty or if its occupant is leaving; an
    // item is cancelled if any older stage asks for a flush.
    task automatic model_comb(output logic [S-1:0] ea, output logic [S-1:0] ek);
        bit down_free;
        bit fl_above;
        down_free = 1'b1;
        fl_above  = 1'b0;
        for (int i = S-1; i >= 0; i--) begin
            ea[i]     = !m_v[i] || (stage_over[i] && down_free);
            down_free = ea[i];
            ek[i]     = fl_above;
            fl_above  = fl_above | flush_req[i];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_rc = '0;
        m_fc = 0;
    endtask

    task automatic model_edge(input logic [S-1:0] ea, input logic [S-1:0] ek);
        bit           nv [S];
        logic [W-1:0] nd [S];
        if (!resetn) begin
            model_clear();
            return;
        end
        if (m_v[S-1] && stage_over[S-1]) m_rc = m_rc + 32'd1;
        if (ek[0] && m_fc < 65535) m_fc++;
        for (int i = 0; i < S; i++) begin
            nv[i] = m_v[i];
            nd[i] = m_d[i];
        end
        for (int j = S-1; j >= 1; j--) begin
            if (ek[j]) nv[j] = 1'b0;
            else if (m_v[j-1] && stage_over[j-1] && ea[j] && !ek[j-1]) begin
                nv[j] = 1'b1;
                nd[j] = stage_fn(j-1, m_d[j-1]);
            end else if (ea[j]) nv[j] = 1'b0;
        end
        if (ek[0]) nv[0] = 1'b0;
        else if (ea[0]) begin
            nv[0] = in_valid;
            if (in_valid) nd[0] = in_data;
        end
        for (int i = 0; i < S; i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
    endtask

    // One clock: called at a falling edge with inputs already set.
    task automatic cycle();
        logic [S-1:0] ea;
        logic [S-1:0] ek;
        model_comb(ea, ek);
        for (int i = 0; i < S-1; i++) nxt_bus[i*W +: W] = stage_fn(i, m_d[i]);
        #1;
        chk_eq("allow_in", 64'(allow_in), 64'(ea));
        chk_eq("in_ready", 64'(in_ready), 64'(ea[0] & ~ek[0]));
        chk_eq("retire_valid", 64'(retire_valid), 64'(m_v[S-1] & stage_over[S-1]));
        if (m_v[S-1]) chk_eq("retire_data", 64'(retire_data), 64'(m_d[S-1]));
        obs_ret   = retire_valid;
        obs_rdata = retire_data;
        obs_rdy   = in_ready;
        @(posedge clk);
        model_edge(ea, ek);
        @(negedge clk);
        chk_eq("stage_valid", 64'(stage_valid), 64'(pack_v()));
        chk_eq("stage_data", 64'(stage_data), 64'(pack_d()));
        chk_eq("occupancy", 64'(occupancy), 64'($countones(pack_v())));
        chk_eq("retire_cnt", 64'(retire_cnt), 64'(m_rc));
        chk_eq("flush_cnt", 64'(flush_cnt), 64'(m_fc));
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic [S-1:0] ov, input logic [S-1:0] fl);
        in_valid   = iv;
        in_data    = id;
        stage_over = ov;
        flush_req  = fl;
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int k = 0; k < S; k++) begin
            drive(1'b1, base + W'(k), 5'b11111, 5'b00000);
            cycle();
        end
    endtask

    task automatic drain();
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        for (int k = 0; k < S+1; k++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [W-1:0] lat_data;
        logic [31:0]  rc_c6;
        bit           all_rdy;
        logic [W-1:0] ret_q [$];
        int           n_ret;

        resetn  = 1'b0;
        xform   = 1'b0;
        nxt_bus = '0;
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        model_clear();
        @(negedge clk);
        cycle();
        cycle();
        resetn = 1'b1;
        #1;
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("rst_valid", 64'(stage_valid), 64'd0);
        chk_eq("rst_occ", 64'(occupancy), 64'd0);
        chk_eq("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk_eq("rst_flush_cnt", 64'(flush_cnt), 64'd0);

        // Single item: accepted at cycle 0, retires at cycle 5.
        drive(1'b1, 8'h11, 5'b11111, 5'b00000);
        cycle();
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        lat      = -1;
        lat_data = '0;
        rc_c6    = '0;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            if (obs_ret && lat < 0) begin
                lat      = c;
                lat_data = obs_rdata;
            end
            if (c == 5) rc_c6 = retire_cnt;
        end
        chk_eq("latency", 64'(lat), 64'd5);
        chk_eq("latency_data", 64'(lat_data), 64'h11);
        chk_eq("retire_cnt_c6", 64'(rc_c6), 64'd1);

        // Back-to-back stream 0x01..0x0A.
        all_rdy = 1'b1;
        ret_q.delete();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, W'(k), 5'b11111, 5'b00000);
            cycle();
            if (!obs_rdy) all_rdy = 1'b0;
            if (obs_ret) ret_q.push_back(obs_rdata);
        end
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_ret) ret_q.push_back(obs_rdata);
        end
        chk_eq("stream_ready", 64'(all_rdy), 64'd1);
        chk_eq("stream_count", 64'(ret_q.size()), 64'd10);
        for (int k = 0; k < ret_q.size(); k++) chk_eq("stream_order", 64'(ret_q[k]), 64'(k+1));

        // Stall at stage 2 on a full pipe.
        fill(8'h20);
        chk_eq("full_occ", 64'(occupancy), 64'd5);
        all_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h25, 5'b11011, 5'b00000);
            cycle();
            if (obs_rdy) all_rdy = 1'b1;
            chk_eq("stall_occ", 64'(occupancy), 64'((k == 0) ? 4 : 3));
        end
        chk_eq("stall_ready_low", 64'(all_rdy), 64'd0);
        chk_eq("stall_valid", 64'(stage_valid), 64'b00111);
        chk_eq("stall_hold", 64'(stage_data[3*W-1:0]), 64'h222324);
        drain();

        // Flush from the last stage. Stage 4 is held that cycle so the
        // surviving item stays visible, then retires normally.
        fill(8'h30);
        drive(1'b1, 8'h99, 5'b01111, 5'b10000);
        cycle();
        chk_eq("flush4_ready", 64'(obs_rdy), 64'd0);
        chk_eq("flush4_valid", 64'(stage_valid), 64'b10000);
        chk_eq("flush4_cnt", 64'(flush_cnt), 64'd1);
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        cycle();
        chk_eq("flush4_retire", 64'(obs_ret), 64'd1);
        chk_eq("flush4_rdata", 64'(obs_rdata), 64'h30);
        drain();

        // Two simultaneous flush requests count once.
        fill(8'h40);
        drive(1'b0, 8'h00, 5'b00111, 5'b01100);
        cycle();
        chk_eq("flush23_valid", 64'(stage_valid), 64'b11000);
        chk_eq("flush23_keep", 64'(stage_data[4*W-1:3*W]), 64'h41);
        chk_eq("flush23_cnt", 64'(flush_cnt), 64'd2);
        drain();

        // Retire counter wrap from 2^32-1.
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_rc = 32'hFFFF_FFFF;
        drive(1'b1, 8'h55, 5'b11111, 5'b00000);
        cycle();
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        for (int c = 1; c <= 5; c++) cycle();
        chk_eq("retire_wrap", 64'(retire_cnt), 64'd0);

        // Reset with items in flight.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h60 + W'(k), 5'b11111, 5'b00000);
            cycle();
        end
        resetn = 1'b0;
        cycle();
        chk_eq("mid_rst_valid", 64'(stage_valid), 64'd0);
        chk_eq("mid_rst_data", 64'(stage_data), 64'd0);
        chk_eq("mid_rst_occ", 64'(occupancy), 64'd0);
        chk_eq("mid_rst_rcnt", 64'(retire_cnt), 64'd0);
        chk_eq("mid_rst_fcnt", 64'(flush_cnt), 64'd0);
        chk_eq("mid_rst_retire", 64'(retire_valid), 64'd0);
        resetn = 1'b1;
        drive(1'b0, 8'h00, 5'b11111, 5'b00000);
        n_ret = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            if (obs_ret) n_ret++;
        end
        chk_eq("post_rst_no_retire", 64'(n_ret), 64'd0);

        // Random traffic with stalls, flushes and occasional resets.
        xform = 1'b1;
        for (int k = 0; k < 800; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = W'($urandom);
            for (int i = 0; i < S; i++) stage_over[i] = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 15) == 0) ? S'($urandom) : '0;
            resetn    = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_chain_ctrl.md
PIPE_CHAIN_CTRL -- requirements
Module: pipe_chain_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning the number of pipeline stages (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 64, meaning the payload bits latched per stage.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  new item offered to stage 0.
REQ-006 SHALL have port in_data  input  WIDTH  payload of the offered item.
REQ-007 SHALL have port in_ready  output  1  item accepted this cycle when in_valid & in_ready.
REQ-008 SHALL have port stage_over  input  STAGES  bit i: stage i logic has finished its current item.
REQ-009 SHALL have port nxt_bus  input  (STAGES-1)*WIDTH  slice i: bus that stage i's logic produces for stage i+1.
REQ-010 SHALL have port flush_req  input  STAGES  bit k: stage k requests cancellation of all younger stages 0..k-1.
REQ-011 SHALL have port stage_valid  output  STAGES  per-stage valid flags.
REQ-012 SHALL have port stage_data  output  STAGES*WIDTH  per-stage latched payload, slice i = stage i.
REQ-013 SHALL have port allow_in  output  STAGES  per-stage allow-in.
REQ-014 SHALL have port retire_valid  output  1  last stage retires this cycle.
REQ-015 SHALL have port retire_data  output  WIDTH  payload of the retiring item.
REQ-016 SHALL have port occupancy  output  $clog2(STAGES+1)  count of set stage_valid bits.
REQ-017 SHALL have port retire_cnt  output  32  total retired items, wrapping.
REQ-018 SHALL have port flush_cnt  output  16  total flush events, saturating.

Function
REQ-019 SHALL compute allow_in[S-1] = ~valid[S-1] | over[S-1].
REQ-020 SHALL compute allow_in[i] = ~valid[i] | (over[i] & allow_in[i+1]) for i<S-1.
REQ-021 SHALL define move[i] = valid[i] & over[i] & allow_in[i+1] & ~kill[i], where kill[i] = 1 iff some flush_req[k] with k>i is set.
REQ-022 SHALL, on move[i], latch nxt_bus slice i into stage i+1 data and set valid[i+1].
REQ-023 SHALL clear valid[i+1] at the clock edge when allow_in[i+1] is set and no move[i] occurs.
REQ-024 SHALL clear valid[i] for every i with kill[i]=1; flush overrides any other update, and stage k itself is unaffected by its own flush_req[k].
REQ-025 SHALL drive in_ready = allow_in[0] & ~(|flush_req[STAGES-1:1]); on accept, latch in_data into stage 0 and set valid[0].
REQ-026 SHALL hold stage data and valid unchanged whenever allow_in is 0 (stall); data of invalid stages is don't-care but SHALL NOT be altered by a stall.
REQ-027 SHALL drive retire_valid = valid[S-1] & over[S-1] combinationally, with retire_data = stage S-1 data.
REQ-028 SHALL increment retire_cnt by 1 on each retire_valid cycle, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL increment flush_cnt once per cycle with |flush_req[STAGES-1:1] set, saturating at 0xFFFF; flush_req[0] is ignored because it kills nothing.
REQ-030 SHALL handle a retire and a flush in the same cycle independently: stage S-1 retires, and the flushed stages are killed.
REQ-031 SHALL give occupancy as a registered population count consistent with the current stage_valid.
REQ-032 SHALL provide a minimum latency of STAGES cycles from accept to retire when all over bits are 1, with throughput of 1 item per cycle.

Reset
REQ-033 SHALL, while resetn=0 at an edge, clear all valid bits, stage data, retire_cnt, flush_cnt and occupancy to 0; in_ready SHALL then equal 1 after reset (all stages empty).
REQ-034 SHALL discard in-flight items when reset is asserted mid-operation, with no retire following the reset.

Verification (STAGES=5, WIDTH=8)
REQ-035 SHALL be covered by this scenario: over=5'b11111, accept 0x11 at cycle 0 -> retire_valid=1 with retire_data=0x11 at cycle 5, retire_cnt=1 at cycle 6.
REQ-036 SHALL be covered by this scenario: stream 0x01..0x0A back-to-back with all over=1 -> 10 consecutive retires in order, in_ready constant 1.
REQ-037 SHALL be covered by this scenario: full pipe, over[2]=0 for 3 cycles -> stages 0-2 hold their data, stages 3-4 drain, in_ready=0, occupancy drops 5->3.
REQ-038 SHALL be covered by this scenario: full pipe, flush_req=5'b10000 one cycle -> valid=5'b10000 next cycle, stage 4 retires normally, flush_cnt=1, input rejected that cycle.
REQ-039 SHALL be covered by this scenario: flush_req=5'b01100 simultaneously -> stages 0-2 killed, stage 3 kept, flush_cnt +1 only.
REQ-040 SHALL be covered by this scenario: retire_cnt preset via 2^32-1 retires (forced) then one retire -> retire_cnt=0; resetn=0 mid-stream -> all outputs 0 next cycle.
